// File: rtl/tag_array_nway.sv
// N-way set-associative tag store with per-set round-robin replacement
// and a one-set-per-cycle flush sequencer. Responses are registered.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | accepting lookup/fill/inval requests
// S_FLUSH | clearing valid bits and rr_ptr of set cnt_q
module tag_array_nway #(
  parameter int TAG_W = 22,
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_idx,
  input  logic [TAG_W-1:0] req_tag,
  output logic             ready,
  input  logic             flush,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic [WAY_W-1:0] rsp_victim,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q;
  logic             last_set;

  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];

  logic             accept;
  logic             is_fill;
  logic             is_inval;
  logic [WAYS-1:0]  match_vec;
  logic             hit;
  logic             all_valid;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] wr_way;

  assign accept   = req_valid & ready;
  assign is_fill  = (req_op == 2'd1);
  assign is_inval = (req_op == 2'd2);
  assign last_set = (cnt_q == IDX_W'(SETS - 1));

  always_ff @(posedge CK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (flush) state_d = S_FLUSH;
      S_FLUSH: if (last_set) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == S_IDLE) & ~flush;
    busy  = (state_q == S_FLUSH);
  end

  always_ff @(posedge CK) begin
    if (RST || state_q == S_IDLE) cnt_q <= '0;
    else                          cnt_q <= cnt_q + IDX_W'(1);
  end

  // Descending scan so the lowest-numbered matching/invalid way wins.
  always_comb begin
    match_vec = '0;
    hit_way   = '0;
    victim    = rr_q[req_idx];
    for (int w = 0; w < WAYS; w++)
      match_vec[w] = valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match_vec[w])          hit_way = WAY_W'(w);
      if (!valid_q[req_idx][w])  victim  = WAY_W'(w);
    end
  end

  assign hit       = |match_vec;
  assign all_valid = &valid_q[req_idx];
  assign wr_way    = hit ? hit_way : victim;

  always_ff @(posedge CK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (state_q == S_FLUSH) begin
      valid_q[cnt_q] <= '0;
      rr_q[cnt_q]    <= '0;
    end else if (accept) begin
      if (is_fill) begin
        valid_q[req_idx][wr_way] <= 1'b1;
        // Only evicting a live way advances the pointer.
        if (WAYS > 1 && !hit && all_valid)
          rr_q[req_idx] <= rr_q[req_idx] + WAY_W'(1);
      end else if (is_inval && hit) begin
        valid_q[req_idx][hit_way] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (!RST && accept && is_fill)
      tag_mem[req_idx][wr_way] <= req_tag;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_way    <= '0;
      rsp_victim <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_hit    <= hit;
        rsp_victim <= victim;
        rsp_way    <= is_fill ? wr_way : hit_way;
      end
    end
  end

endmodule

// File: tb/tb_tag_array_nway.sv
// Directed bench for tag_array_nway: scoreboard of expected responses,
// flush timing and reset-during-flush behaviour.
module tb_tag_array_nway;
  localparam int TAG_W = 22;
  localparam int SETS  = 64;
  localparam int WAYS  = 2;
  localparam int IDX_W = 6;
  localparam int WAY_W = 1;

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_FILL   = 2'd1;
  localparam logic [1:0] OP_INVAL  = 2'd2;

  logic             CK = 1'b0;
  logic             RST;
  logic             req_valid;
  logic [1:0]       req_op;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             ready;
  logic             flush;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [WAY_W-1:0] rsp_way;
  logic [WAY_W-1:0] rsp_victim;
  logic             busy;

  tag_array_nway #(.TAG_W(TAG_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .CK(CK), .RST(RST), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_tag(req_tag), .ready(ready), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_victim(rsp_victim), .busy(busy)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic  hit;
    int    way;
    int    victim;
    string name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // One clock: inputs already driven; checks the response produced by this edge.
  task automatic cycle(input bit exp_acc);
    exp_t e;
    @(posedge CK);
    #1;
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_acc});
    if (rsp_valid) begin
      chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".hit"},    {31'd0, rsp_hit}, {31'd0, e.hit});
        chk({e.name, ".way"},    {31'd0, rsp_way}, e.way);
        chk({e.name, ".victim"}, {31'd0, rsp_victim}, e.victim);
      end
    end
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic req(input logic [1:0] op, input int idx, input logic [TAG_W-1:0] tag,
                     input logic eh, input int ew, input int ev, input string nm);
    exp_t e;
    req_valid = 1'b1;
    req_op    = op;
    req_idx   = IDX_W'(idx);
    req_tag   = tag;
    e.hit = eh; e.way = ew; e.victim = ev; e.name = nm;
    sb.push_back(e);
    cycle(1'b1);
  endtask

  function automatic logic [TAG_W-1:0] flush_tag(input int s);
    if (s == 5) return TAG_W'('h444);
    if (s == 9) return TAG_W'('hABC);
    return TAG_W'('h100 + s);
  endfunction

  initial begin
    int lo_cnt;
    bit seen_rsp;

    RST = 1'b1; req_valid = 1'b0; req_op = '0; req_idx = '0; req_tag = '0; flush = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    chk("rst.rsp_valid",  {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_hit",    {31'd0, rsp_hit}, 32'd0);
    chk("rst.rsp_way",    {31'd0, rsp_way}, 32'd0);
    chk("rst.rsp_victim", {31'd0, rsp_victim}, 32'd0);
    chk("rst.busy",       {31'd0, busy}, 32'd0);
    RST = 1'b0;
    @(posedge CK); #1;
    chk("rst.ready", {31'd0, ready}, 32'd1);

    req(OP_LOOKUP, 5, 'h3ABCD, 0, 0, 0, "lk_empty");

    req(OP_FILL,   5, 'h111, 0, 0, 0, "fill5_a");
    req(OP_FILL,   5, 'h222, 0, 1, 1, "fill5_b");
    req(OP_LOOKUP, 5, 'h222, 1, 1, 0, "lk5_b");
    req(OP_FILL,   5, 'h333, 0, 0, 0, "fill5_c");
    req(OP_FILL,   5, 'h444, 0, 1, 1, "fill5_d");
    req(OP_LOOKUP, 5, 'h333, 1, 0, 0, "lk5_c");
    req(OP_LOOKUP, 5, 'h111, 0, 0, 0, "lk5_evicted");

    req(OP_FILL,   7, 'h111, 0, 0, 0, "fill7_a");
    req(OP_FILL,   7, 'h111, 1, 0, 1, "fill7_dup");
    req(OP_LOOKUP, 7, 'h999, 0, 0, 1, "lk7_one_valid");
    req(OP_INVAL,  7, 'h111, 1, 0, 1, "inv7");
    req(OP_LOOKUP, 7, 'h111, 0, 0, 0, "lk7_gone");

    req(OP_FILL,   9, 'hABC, 0, 0, 0, "fill9");
    req(OP_LOOKUP, 9, 'hABC, 1, 0, 1, "lk9_hazard");
    req(OP_INVAL,  9, 'h555, 0, 0, 1, "inv9_miss");

    for (int s = 10; s < 14; s++) req(OP_FILL, s, flush_tag(s), 0, 0, 0, "fill_pre");

    // Flush and request in the same cycle: flush wins.
    flush = 1'b1; req_valid = 1'b1; req_op = OP_FILL; req_idx = IDX_W'(20); req_tag = 'h777;
    #1;
    chk("flush.ready_low", {31'd0, ready}, 32'd0);
    cycle(1'b0);
    chk("flush.busy", {31'd0, busy}, 32'd1);
    lo_cnt = 0;
    seen_rsp = 1'b0;
    while (ready === 1'b0 && lo_cnt < 200) begin
      lo_cnt++;
      @(posedge CK); #1;
      if (rsp_valid) seen_rsp = 1'b1;
    end
    chk("flush.ready_low_cycles", lo_cnt, SETS);
    chk("flush.no_rsp", {31'd0, seen_rsp}, 32'd0);
    chk("flush.busy_done", {31'd0, busy}, 32'd0);
    for (int s = 0; s < SETS; s++) req(OP_LOOKUP, s, flush_tag(s), 0, 0, 0, "lk_post_flush");

    // Reset while the flush is at cnt=20, together with a request.
    for (int s = 21; s < SETS; s++) begin
      req(OP_FILL, s, TAG_W'('h200 + s), 0, 0, 0, "fill_hi_a");
      req(OP_FILL, s, TAG_W'('h300 + s), 0, 1, 1, "fill_hi_b");
    end
    flush = 1'b1;
    cycle(1'b0);
    repeat (20) @(posedge CK);
    #1;
    chk("rflush.busy_mid", {31'd0, busy}, 32'd1);
    RST = 1'b1; req_valid = 1'b1; req_op = OP_FILL; req_idx = IDX_W'(30); req_tag = 'h777;
    cycle(1'b0);
    chk("rflush.busy_after_rst", {31'd0, busy}, 32'd0);
    RST = 1'b0;
    #1;
    chk("rflush.ready", {31'd0, ready}, 32'd1);
    for (int s = 0; s < SETS; s++) req(OP_LOOKUP, s, TAG_W'('h200 + s), 0, 0, 0, "lk_post_rst");
    req(OP_LOOKUP, 30, 'h777, 0, 0, 0, "lk_rst_req_ignored");

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tag_array_nway.md
# tag_array_nway

Parametrised N-way set-associative tag store, the successor to the single-way 22-bit × 64-entry tag SRAM model in the cache subsystem. Per set it holds WAYS tags with valid bits and a round-robin replacement pointer. It performs lookup, fill and invalidate in one cycle, with the registered response one cycle later. A flush state machine invalidates the whole array one set per cycle.

## Interface
Parameters:
- TAG_W, 22, tag width in bits
- SETS, 64, number of sets (power of two, ≥2)
- WAYS, 2, associativity (power of two, 1..8)
- IDX_W, $clog2(SETS), set index width (derived)
- WAY_W, (WAYS>1 ? $clog2(WAYS) : 1), way number width (derived)

Ports:
- CK  in  1  clock; all logic on posedge
- RST  in  1  reset, synchronous, active-high
- req_valid  in  1  request strobe
- req_op  in  2  0=LOOKUP, 1=FILL, 2=INVAL, 3=reserved (accepted, treated as LOOKUP)
- req_idx  in  IDX_W  set index
- req_tag  in  TAG_W  tag to compare or write
- ready  out  1  request accepted when req_valid & ready; ready = (state==IDLE) & ~flush (combinational)
- flush  in  1  start invalidate-all; sampled only in IDLE
- rsp_valid  out  1  response strobe, one cycle per accepted request
- rsp_hit  out  1  tag matched a valid way
- rsp_way  out  WAY_W  matched way (LOOKUP/INVAL) or written way (FILL)
- rsp_victim  out  WAY_W  way a FILL to this set would use now
- busy  out  1  high while flush is in progress

## Operation
- Storage: tag[SETS][WAYS] (no reset), valid[SETS][WAYS], rr_ptr[SETS] (WAY_W bits).
- Match: way w matches when valid[idx][w] & tag[idx][w]==req_tag. If several ways match, the lowest-numbered way wins.
- Victim: the lowest-numbered invalid way. If all ways are valid, the victim is rr_ptr[idx].
- LOOKUP: no state change. rsp_hit and rsp_way report the match; rsp_way=0 on a miss.
- FILL: if the tag already matches, rewrite that way (no duplicates), rsp_hit=1, rr_ptr unchanged.
  - Otherwise write req_tag into the victim way and set valid, rsp_hit=0.
  - rr_ptr[idx] increments modulo WAYS only when the victim was a valid way.
  - rsp_way reports the written way.
- INVAL: clear valid of the matched way. rsp_hit reports whether a match existed. Tags and rr_ptr are unchanged.
- rsp_victim is computed from the pre-update state of the accepted request.
- FSM states:
  - IDLE → FLUSH when flush=1.
  - FLUSH: cnt runs 0..SETS-1, one set per cycle, clearing all valid bits and rr_ptr of set cnt.
  - FLUSH → IDLE after the cycle where cnt==SETS-1.
- Priority: flush beats req_valid in the same cycle; the request is not accepted. flush while in FLUSH is ignored.
- WAYS=1: the victim is always way 0 and rr_ptr is constant 0.

## Timing
- Request accepted at edge n. State is updated at edge n. The response is registered and visible after edge n, so rsp_valid is high in cycle n+1 only.
- Back-to-back accepts are allowed every cycle. A request at n+1 to the same set observes the update made at n (no stale read).
- Flush sampled at edge n:
  - busy=1 and ready=0 from cycle n+1 through cycle n+SETS.
  - ready may rise in cycle n+SETS+1.
  - No rsp_valid for the flush itself.
- Reset (any state, including mid-flush):
  - State returns to IDLE and all valid and rr_ptr are cleared in one cycle.
  - rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_victim=0, busy=0.
  - ready=1 in the cycle after RST deasserts (flush low).
- Reset asserted together with req_valid or flush: reset wins and both are ignored.

## Test plan
- After reset, LOOKUP idx=5 tag=0x3ABCD → rsp_valid in cycle n+1, rsp_hit=0, rsp_victim=0.
- WAYS=2: FILL idx=5 tags 0x111 then 0x222 → rsp_way 0 then 1. LOOKUP 0x222 → hit, way=1. FILL 0x333 → written way 0, rr_ptr→1. Next FILL 0x444 → way 1.
- FILL 0x111 twice into idx=7 → second response rsp_hit=1, same way, valid count 1. INVAL 0x111 → hit=1. LOOKUP 0x111 → miss.
- Same-cycle hazard: FILL idx=9 at n, LOOKUP idx=9 same tag at n+1 → rsp_hit=1 in cycle n+2.
- Fill several sets, assert flush together with req_valid → request not accepted. ready=0 for exactly SETS=64 cycles. Afterwards every LOOKUP misses and rsp_victim=0.
- Assert RST at flush cnt=20 → busy=0 next cycle. All sets invalid, with no leftover valid entries in sets 21..63.
